// File: rtl/enreg_rr_arbiter_if.sv
// Bus bundle between the requesters and the shared enabled-register arbiter.
// The requester side drives the request lanes and sees grant, register and status.
interface enreg_rr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        last;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        gnt;
    logic [DATA_W-1:0]       q;
    logic                    load;
    logic [2:0]              owner;
    logic                    busy;

    modport master (
        output req,
        output last,
        output wdata,
        input  gnt,
        input  q,
        input  load,
        input  owner,
        input  busy
    );

    modport slave (
        input  req,
        input  last,
        input  wdata,
        output gnt,
        output q,
        output load,
        output owner,
        output busy
    );
endinterface

// File: rtl/enreg_rr_arbiter.sv
// Round-robin arbiter and write sequencer for one shared enabled register.
// A grant is a burst of back-to-back loads from its owner, capped at MAX_HOLD
// loads, after which ownership passes on to the next requester in rotation.
module enreg_rr_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                clk_amisha,
    input  logic                reset_amisha,
    enreg_rr_arbiter_if.slave   bus
);

    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [2:0] OWNER_RESET = 3'(N_REQ - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [N_REQ-1:0]    gnt_reg;
    logic [N_REQ-1:0]    gnt_next;
    logic [2:0]          owner_reg;
    logic [2:0]          owner_next;
    logic [2:0]          last_owner;
    logic [2:0]          last_owner_next;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W-1:0]   hold_next;
    logic [DATA_W-1:0]   q_reg;
    logic                load_now;
    logic                owner_req;
    logic                owner_last;
    logic [DATA_W-1:0]   owner_lane;
    logic                timeout;
    logic                release_now;
    logic [N_REQ-1:0]    cand;
    logic [2:0]          pick_idx;

    // First set bit of mask scanning upward from after_idx+1 and wrapping,
    // so after_idx itself is always ranked last.
    function automatic logic [2:0] pick(input logic [N_REQ-1:0] mask,
                                        input logic [2:0] after_idx);
        logic [2:0] result;
        logic       found;
        result = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && mask[i] && (i > int'(after_idx))) begin
                result = 3'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && mask[i]) begin
                result = 3'(i);
                found  = 1'b1;
            end
        end
        return result;
    endfunction

    function automatic logic [N_REQ-1:0] one_hot(input logic [2:0] idx);
        logic [N_REQ-1:0] vec;
        vec = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (idx == 3'(i)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // The registered one-hot grant selects the owner's request, last marker and lane.
    always_comb begin
        owner_req  = |(bus.req & gnt_reg);
        owner_last = |(bus.last & gnt_reg);
        owner_lane = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_reg[i]) begin
                owner_lane = bus.wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state, handoff and load decision for the two-state sequencer.
    always_comb begin
        state_next      = state;
        gnt_next        = gnt_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner;
        hold_next       = hold_cnt;
        load_now        = 1'b0;
        timeout         = 1'b0;
        release_now     = 1'b0;
        cand            = '0;
        pick_idx        = '0;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    pick_idx        = pick(bus.req, last_owner);
                    state_next      = GRANT;
                    gnt_next        = one_hot(pick_idx);
                    owner_next      = pick_idx;
                    last_owner_next = pick_idx;
                    hold_next       = '0;
                end
            end
            GRANT: begin
                load_now    = owner_req;
                timeout     = owner_req && !owner_last && (hold_cnt == HOLD_LAST);
                release_now = !owner_req || owner_last || (hold_cnt == HOLD_LAST);
                if (!release_now) begin
                    hold_next = hold_cnt + 1'b1;
                end else begin
                    cand = timeout ? bus.req : (bus.req & ~gnt_reg);
                    hold_next = '0;
                    if (|cand) begin
                        pick_idx        = pick(cand, last_owner);
                        gnt_next        = one_hot(pick_idx);
                        owner_next      = pick_idx;
                        last_owner_next = pick_idx;
                    end else begin
                        state_next = IDLE;
                        gnt_next   = '0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                gnt_next   = '0;
                hold_next  = '0;
            end
        endcase
    end

    // Sequencer state, grant bookkeeping and burst counter.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            state      <= IDLE;
            gnt_reg    <= '0;
            owner_reg  <= '0;
            last_owner <= OWNER_RESET;
            hold_cnt   <= '0;
        end else begin
            state      <= state_next;
            gnt_reg    <= gnt_next;
            owner_reg  <= owner_next;
            last_owner <= last_owner_next;
            hold_cnt   <= hold_next;
        end
    end

    // The shared enabled register: loads the owner's lane only when load is high.
    always_ff @(posedge clk_amisha or posedge reset_amisha) begin
        if (reset_amisha) begin
            q_reg <= '0;
        end else if (load_now) begin
            q_reg <= owner_lane;
        end
    end

    assign bus.gnt   = gnt_reg;
    assign bus.q     = q_reg;
    assign bus.load  = load_now;
    assign bus.owner = owner_reg;
    assign bus.busy  = (state == GRANT);

endmodule

// File: doc/enreg_rr_arbiter.md
Name: enreg_rr_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared DATA_W-bit enabled register (D-register with load enable, async clear).
- Up to N_REQ requesters compete for the register. Each grant is a burst of back-to-back loads from the owning requester.
- Bursts are bounded by MAX_HOLD so no requester can starve the others.

Parameters:
- N_REQ, 4, number of requesters; supported values 2..8.
- DATA_W, 8, width of the shared register and of each write lane.
- MAX_HOLD, 4, maximum consecutive load cycles per grant; must be >= 1.

Ports:
- clk_amisha  in  1  clock, rising edge.
- reset_amisha  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester request, level, held high for the whole burst.
- last  in  N_REQ  per-requester final-word marker; only meaningful when req of the same bit is high.
- wdata  in  N_REQ*DATA_W  write lanes; lane i = wdata[i*DATA_W +: DATA_W].
- gnt  out  N_REQ  registered one-hot grant; all-zero when idle.
- q  out  DATA_W  shared register contents.
- load  out  1  high in the cycle in which q loads at the next edge; combinational from state and req.
- owner  out  3  index of the current grant holder; valid only while busy=1.
- busy  out  1  high when state is GRANT.

Behaviour:
- Reset is asynchronous and active-high on reset_amisha; the clock is clk_amisha. Reset values:
  - state=IDLE, gnt=0, q=0, busy=0, owner=0, hold_cnt=0.
  - last_owner=N_REQ-1, so requester 0 has top priority after reset.
- Reset asserted mid-burst aborts the burst immediately; no partial-cycle load.
- States: IDLE and GRANT.
- Arbitration function pick(mask): first set bit of mask, scanning from last_owner+1 upward and wrapping modulo N_REQ.
- IDLE:
  - If |req: next state GRANT, gnt <= one-hot(pick(req)), owner and last_owner <= that index, hold_cnt <= 0.
  - Else stay in IDLE.
  - No load occurs in IDLE.
  - Latency from a req rising to gnt high is one clock.
- GRANT, with owner i:
  - load = req[i]. When load=1, q <= lane i at the next edge and hold_cnt increments. Otherwise q holds.
  - Release condition rel = !req[i] | (req[i] & last[i]) | (req[i] & hold_cnt==MAX_HOLD-1).
  - If rel is false: stay in GRANT with the same owner.
  - If rel is true, build cand = req with bit i cleared, unless release was by hold timeout with last[i]=0. In that case bit i stays in cand but is ranked lowest by the round-robin order.
    - cand nonzero: GRANT to pick(cand) next cycle. This is a direct handoff with no idle bubble; hold_cnt <= 0.
    - cand zero: IDLE, gnt <= 0.
- The word presented together with last is loaded; release takes effect on the same edge.
- req dropping without last: no load that cycle, and the grant is released.
- Single requester, continuous req, no last: grant re-issued to the same requester after each MAX_HOLD loads. No gap in loads, since the handoff is to itself.
- Inputs from non-owners are ignored; their last bits are don't-care.
- gnt is always one-hot or zero. busy equals |gnt. owner is stable for the whole grant.
- MAX_HOLD=1: every grant is exactly one load, so the arbiter rotates every cycle.

Test Plan:
1. Reset with req=0 -> q=0, gnt=0, busy=0. Hold reset for 3 cycles with wdata toggling -> q stays 0.
2. Single burst: req=4'b0010, lane1 = 0xA1, 0xA2, 0xA3 on consecutive cycles, last on the 3rd.
   - Expect gnt=0010 one cycle after req, q = A1, A2, A3 on three successive edges, then IDLE with gnt=0.
3. Fairness: req=4'b1111 continuously, last=0, MAX_HOLD=4.
   - Expect grants in order 0,1,2,3,0, each exactly 4 load cycles, no idle cycle between grants.
4. Starvation bound: req0 high forever, req2 rises mid-burst.
   - Expect req0 released after at most 4 loads, gnt=0100 on the very next cycle, then back to requester 0.
5. Abort: owner 3 drops req after 2 loads with no last, no other requests.
   - Expect no load that cycle, q keeps the 2nd word, return to IDLE.
6. Async reset asserted between clock edges during a burst:
   - Expect gnt=0 and q=0 immediately.
   - After release, requester 0 wins when req=4'b1001.
